spi_txn_sequencer: RTL and testbench

//  Upstream feeder for the byte-level SPI master. Buffers host TX bytes in a FIFO
//  and issues a host-requested burst of N bytes to the master one byte at a time

---
 rtl/spi_txn_sequencer.sv | 279 +++++++++++++++++++++++++++
 tb/tb_spi_txn_sequencer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_sequencer.sv
// ---------------------------------------------------------------------------
// spi_txn_sequencer
//
// Purpose:
//   Upstream feeder for a byte-level SPI master. Host TX bytes are buffered in
//   a first-word fall-through FIFO. When the host requests a burst of N bytes
//   (i_go + i_len), the sequencer hands bytes to the master one at a time over
//   a start/ready handshake. Each byte returned by the master is captured into
//   an RX FIFO for the host to read back.
//
// Ports:
//   i_clk, i_rst_n     clock and asynchronous active-low reset
//   i_wr_valid/o_wr_ready/i_wr_data   host -> TX FIFO write port
//   o_rd_valid/i_rd_ready/o_rd_data   RX FIFO -> host read port (FWFT head)
//   i_go, i_len        burst request pulse and burst length
//   o_busy             burst in progress (FETCH/ISSUE/WAIT)
//   o_done             one-cycle pulse at burst end (or for a zero-length go)
//   o_rx_overflow      sticky: an RX byte was dropped because RX FIFO was full
//   o_spi_tx_byte      byte presented to the master, stable through the transfer
//   o_spi_tx_start     one-cycle launch strobe to the master
//   i_spi_tx_ready     one-cycle pulse from master: transfer complete
//   i_spi_rx_byte      byte received by master, valid with i_spi_tx_ready
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// spi_txn_sequencer_fifo
//
// Purpose:
//   8-bit first-word fall-through FIFO. The head entry is always visible on
//   'head' while 'empty' is low. Push is ignored when full, pop is ignored
//   when empty, so callers may drive push/pop unconditionally.
//
// Ports:
//   clk, rst_n         clock and asynchronous active-low reset
//   push, push_data    write request and data
//   pop                remove head entry
//   head               current head entry (valid when !empty)
//   empty, full        exact occupancy flags
// ---------------------------------------------------------------------------
module spi_txn_sequencer_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_FULL);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Fall-through read: head tracks the read pointer combinationally.
  assign head = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

module spi_txn_sequencer #(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16,
  parameter int LEN_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  input  logic [7:0]       i_wr_data,
  output logic             o_rd_valid,
  input  logic             i_rd_ready,
  output logic [7:0]       o_rd_data,
  input  logic             i_go,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_rx_overflow,
  output logic [7:0]       o_spi_tx_byte,
  output logic             o_spi_tx_start,
  input  logic             i_spi_tx_ready,
  input  logic [7:0]       i_spi_rx_byte
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state_reg;
  logic [LEN_W-1:0] rem_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             overflow_reg;
  logic [7:0]       tx_byte_reg;
  logic             tx_start_reg;

  logic       tx_head_empty;
  logic       tx_full;
  logic [7:0] tx_head;
  logic       tx_pop;

  logic       rx_empty;
  logic       rx_full;
  logic [7:0] rx_head;
  logic       rx_push;

  // ------------------------------------------------------------------------
  // FIFOs
  // ------------------------------------------------------------------------
  spi_txn_sequencer_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (i_wr_valid),
    .push_data (i_wr_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .empty     (tx_head_empty),
    .full      (tx_full)
  );

  spi_txn_sequencer_fifo #(
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (rx_push),
    .push_data (i_spi_rx_byte),
    .pop       (i_rd_ready),
    .head      (rx_head),
    .empty     (rx_empty),
    .full      (rx_full)
  );

  // The FSM consumes the TX head in the same edge it latches it into the
  // master-facing byte register, so the two always agree.
  assign tx_pop  = (state_reg == S_FETCH) && !tx_head_empty;

  // Ready pulses are only meaningful while a transfer is outstanding; a pulse
  // from a transfer disowned by reset lands in IDLE and is dropped here.
  // When the RX FIFO is full the FIFO itself refuses the push.
  assign rx_push = (state_reg == S_WAIT) && i_spi_tx_ready;

  assign o_wr_ready = !tx_full;
  assign o_rd_valid = !rx_empty;
  assign o_rd_data  = rx_head;

  assign o_busy         = busy_reg;
  assign o_done         = done_reg;
  assign o_rx_overflow  = overflow_reg;
  assign o_spi_tx_byte  = tx_byte_reg;
  assign o_spi_tx_start = tx_start_reg;

  // ------------------------------------------------------------------------
  // Burst sequencer. All outputs are registered and change together with the
  // state, so o_busy/o_done/o_spi_tx_start line up exactly with the state
  // they describe.
  // ------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= S_IDLE;
      rem_reg      <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      tx_byte_reg  <= '0;
      tx_start_reg <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      done_reg     <= 1'b0;
      tx_start_reg <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (i_go) begin
            if (i_len == '0) begin
              // Zero-length burst completes immediately without touching
              // the master or the overflow flag.
              done_reg <= 1'b1;
            end else begin
              rem_reg      <= i_len;
              overflow_reg <= 1'b0;
              busy_reg     <= 1'b1;
              state_reg    <= S_FETCH;
            end
          end
        end

        S_FETCH: begin
          // Stalls here for as long as the host leaves the TX FIFO empty.
          if (!tx_head_empty) begin
            tx_byte_reg  <= tx_head;
            tx_start_reg <= 1'b1;
            state_reg    <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          state_reg <= S_WAIT;
        end

        S_WAIT: begin
          if (i_spi_tx_ready) begin
            if (rx_full) begin
              overflow_reg <= 1'b1;
            end
            rem_reg <= rem_reg - LEN_ONE;
            if (rem_reg > LEN_ONE) begin
              state_reg <= S_FETCH;
            end else begin
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= S_DONE;
            end
          end
        end

        S_DONE: begin
          state_reg <= S_IDLE;
        end

        default: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// ---------------------------------------------------------------------------
// tb_spi_txn_sequencer
//
// Purpose:
//   Directed bench for spi_txn_sequencer. Stimulus pushes the expected master
//   bytes and expected host RX bytes into scoreboard queues; a monitor checks
//   every start strobe and every host RX pop against those queues. A simple
//   SPI master model answers each start with ~byte ten cycles later.
// ---------------------------------------------------------------------------
module tb_spi_txn_sequencer;

  localparam int LEN_W = 8;

  logic             clk;
  logic             rst_n;
  logic             wr_valid;
  logic             wr_ready;
  logic [7:0]       wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [7:0]       rd_data;
  logic             go;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;
  logic             rx_overflow;
  logic [7:0]       spi_tx_byte;
  logic             spi_tx_start;
  logic             spi_tx_ready;
  logic [7:0]       spi_rx_byte;

  int total;
  int bad;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];

  bit model_en;
  int inject_cnt;

  spi_txn_sequencer #(
    .TX_DEPTH (16),
    .RX_DEPTH (16),
    .LEN_W    (LEN_W)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_wr_valid     (wr_valid),
    .o_wr_ready     (wr_ready),
    .i_wr_data      (wr_data),
    .o_rd_valid     (rd_valid),
    .i_rd_ready     (rd_ready),
    .o_rd_data      (rd_data),
    .i_go           (go),
    .i_len          (len),
    .o_busy         (busy),
    .o_done         (done),
    .o_rx_overflow  (rx_overflow),
    .o_spi_tx_byte  (spi_tx_byte),
    .o_spi_tx_start (spi_tx_start),
    .i_spi_tx_ready (spi_tx_ready),
    .i_spi_rx_byte  (spi_rx_byte)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SPI master model: answers a start strobe with ~byte ten cycles later.
  // Reset disowns any transfer in flight. inject_cnt requests a stray
  // ready pulse carrying 8'h77.
  initial begin : spi_model
    int cnt;
    int seen;
    logic [7:0] b;
    cnt = 0;
    seen = 0;
    b = '0;
    spi_tx_ready = 1'b0;
    spi_rx_byte = '0;
    forever begin
      @(negedge clk);
      spi_tx_ready = 1'b0;
      if (!rst_n) begin
        cnt = 0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          spi_tx_ready = 1'b1;
          spi_rx_byte = ~b;
        end
      end else if (spi_tx_start && model_en) begin
        b = spi_tx_byte;
        cnt = 10;
      end
      if (seen != inject_cnt) begin
        seen = inject_cnt;
        spi_tx_ready = 1'b1;
        spi_rx_byte = 8'h77;
      end
    end
  end

  // Scoreboard monitor: compares every master start and host RX pop.
  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (spi_tx_start) begin
        total++;
        if (exp_tx.size() == 0) begin
          bad++;
          $display("FAIL tx_start: got unexpected byte %02h, required no strobe", spi_tx_byte);
        end else begin
          e = exp_tx.pop_front();
          if (spi_tx_byte !== e) begin
            bad++;
            $display("FAIL tx_byte: got %02h required %02h", spi_tx_byte, e);
          end else begin
            $display("tx start byte=%02h ok", spi_tx_byte);
          end
        end
      end
      if (rd_valid && rd_ready) begin
        total++;
        if (exp_rx.size() == 0) begin
          bad++;
          $display("FAIL rx_pop: got unexpected byte %02h, required empty", rd_data);
        end else begin
          e = exp_rx.pop_front();
          if (rd_data !== e) begin
            bad++;
            $display("FAIL rx_byte: got %02h required %02h", rd_data, e);
          end else begin
            $display("rx pop byte=%02h ok", rd_data);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end else begin
      $display("check %s = %0h ok", name, act);
    end
  endtask

  task automatic wr(input logic [7:0] d);
    int waited;
    waited = 0;
    while (!wr_ready && waited < 60) begin
      tick();
      waited++;
    end
    if (!wr_ready) begin
      chk("wr_ready_timeout", 32'(wr_ready), 1);
    end
    wr_valid = 1'b1;
    wr_data = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic start_burst(input logic [LEN_W-1:0] n);
    go = 1'b1;
    len = n;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_done(input int max, output int n);
    bit seen;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      tick();
      if (done) begin
        n++;
        seen = 1'b1;
      end
    end
    if (seen) begin
      for (int i = 0; i < 6; i++) begin
        tick();
        if (done) n++;
      end
    end
  endtask

  task automatic wait_start(input int max, output bit found);
    found = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (spi_tx_start) begin
        found = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic drain(input int max);
    rd_ready = 1'b1;
    for (int i = 0; i < max; i++) begin
      if (!rd_valid) break;
      tick();
    end
    rd_ready = 1'b0;
  endtask

  initial begin : main
    int n;
    bit found;
    bit stalled_ok;
    logic [7:0] b;

    total = 0;
    bad = 0;
    model_en = 1'b0;
    inject_cnt = 0;
    rst_n = 1'b0;
    wr_valid = 1'b0;
    wr_data = '0;
    rd_ready = 1'b0;
    go = 1'b0;
    len = '0;

    // ---------------- Test 1: reset state and reset mid-WAIT ----------------
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_start", 32'(spi_tx_start), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_wr_ready", 32'(wr_ready), 1);
    chk("rst_overflow", 32'(rx_overflow), 0);
    rst_n = 1'b1;
    tick();

    exp_tx.push_back(8'h42);
    wr(8'h42);
    start_burst(8'd1);
    wait_start(10, found);
    chk("t1_start_seen", 32'(found), 1);
    tick();
    tick();
    chk("t1_busy_in_wait", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t1_async_busy", 32'(busy), 0);
    chk("t1_async_start", 32'(spi_tx_start), 0);
    chk("t1_async_rd_valid", 32'(rd_valid), 0);
    chk("t1_async_wr_ready", 32'(wr_ready), 1);
    tick();
    rst_n = 1'b1;
    inject_cnt++;
    repeat (3) tick();
    chk("t1_stray_ready_rd_valid", 32'(rd_valid), 0);
    chk("t1_stray_ready_busy", 32'(busy), 0);
    model_en = 1'b1;

    // ---------------- Test 2: three-byte burst ----------------
    exp_tx.push_back(8'hA5); exp_rx.push_back(8'h5A);
    exp_tx.push_back(8'h3C); exp_rx.push_back(8'hC3);
    exp_tx.push_back(8'hFF); exp_rx.push_back(8'h00);
    wr(8'hA5);
    wr(8'h3C);
    wr(8'hFF);
    start_burst(8'd3);
    chk("t2_busy_after_go", 32'(busy), 1);
    chk("t2_start_not_yet", 32'(spi_tx_start), 0);
    tick();
    chk("t2_go_to_start_2cyc", 32'(spi_tx_start), 1);
    wait_done(200, n);
    chk("t2_done_count", 32'(n), 1);
    chk("t2_busy_after", 32'(busy), 0);
    drain(20);
    chk("t2_rx_all_read", 32'(exp_rx.size()), 0);

    // ---------------- Test 3: zero-length burst ----------------
    start_burst(8'd0);
    chk("t3_done_next_cycle", 32'(done), 1);
    chk("t3_busy_zero", 32'(busy), 0);
    tick();
    chk("t3_done_single", 32'(done), 0);
    chk("t3_no_start", 32'(spi_tx_start), 0);
    chk("t3_busy_still_zero", 32'(busy), 0);

    // ---------------- Test 4: stall in FETCH on empty TX FIFO ----------------
    exp_tx.push_back(8'h11); exp_rx.push_back(8'hEE);
    exp_tx.push_back(8'h22); exp_rx.push_back(8'hDD);
    start_burst(8'd2);
    stalled_ok = 1'b1;
    repeat (5) begin
      tick();
      stalled_ok = stalled_ok && busy && !spi_tx_start;
    end
    chk("t4_stalled_busy", 32'(stalled_ok), 1);
    wr(8'h11);
    chk("t4_start_not_yet", 32'(spi_tx_start), 0);
    tick();
    chk("t4_start_2cyc_after_write", 32'(spi_tx_start), 1);
    repeat (20) tick();
    chk("t4_stalled_second", 32'(busy), 1);
    wr(8'h22);
    wait_done(100, n);
    chk("t4_done_count", 32'(n), 1);
    drain(20);

    // ---------------- Test 5: RX overflow ----------------
    for (int i = 0; i < 18; i++) begin
      b = 8'h80 + 8'(i);
      exp_tx.push_back(b);
      if (i < 16) exp_rx.push_back(~b);
    end
    for (int i = 0; i < 16; i++) begin
      b = 8'h80 + 8'(i);
      wr(b);
    end
    chk("t5_tx_full", 32'(wr_ready), 0);
    start_burst(8'd18);
    chk("t5_busy", 32'(busy), 1);
    wr(8'h90);
    wr(8'h91);
    wait_done(1000, n);
    chk("t5_done_count", 32'(n), 1);
    chk("t5_overflow_set", 32'(rx_overflow), 1);
    chk("t5_rd_valid", 32'(rd_valid), 1);
    drain(40);
    chk("t5_rx_kept_16", 32'(exp_rx.size()), 0);
    chk("t5_overflow_sticky", 32'(rx_overflow), 1);
    exp_tx.push_back(8'h5C); exp_rx.push_back(8'hA3);
    wr(8'h5C);
    start_burst(8'd1);
    chk("t5_go_clears_overflow", 32'(rx_overflow), 0);
    wait_done(100, n);
    chk("t5_second_done", 32'(n), 1);
    drain(20);

    // ---------------- Test 6: full FIFO, push+pop, ignored go ----------------
    for (int i = 0; i < 16; i++) begin
      b = 8'h30 + 8'(i);
      wr(b);
    end
    chk("t6_full_wr_ready", 32'(wr_ready), 0);
    exp_tx.push_back(8'h30); exp_rx.push_back(8'hCF);
    exp_tx.push_back(8'h31); exp_rx.push_back(8'hCE);
    exp_tx.push_back(8'h32); exp_rx.push_back(8'hCD);
    start_burst(8'd3);
    wait_start(10, found);
    chk("t6_start_seen", 32'(found), 1);
    chk("t6_wr_ready_after_pop", 32'(wr_ready), 1);
    repeat (3) tick();
    start_burst(8'd1);               // ignored: burst in progress
    repeat (7) tick();
    // Now in the second FETCH cycle: write in the same cycle as the pop.
    chk("t6_fetch_no_start", 32'(spi_tx_start), 0);
    wr_valid = 1'b1;
    wr_data = 8'h50;
    tick();
    wr_valid = 1'b0;
    chk("t6_pop_same_edge", 32'(spi_tx_start), 1);
    chk("t6_push_pop_count_same", 32'(wr_ready), 1);
    wait_done(100, n);
    chk("t6_done_count", 32'(n), 1);
    wr(8'h60);
    chk("t6_count_15", 32'(wr_ready), 1);
    wr(8'h61);
    chk("t6_count_16_full", 32'(wr_ready), 0);
    drain(20);

    chk("end_tx_queue_empty", 32'(exp_tx.size()), 0);
    chk("end_rx_queue_empty", 32'(exp_rx.size()), 0);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
